// File: rtl/sample_capture_ctrl.sv
// sample_capture_ctrl
// Sequences one capture session in the sample_clk domain. A start command
// runs the session through these steps in order:
//   1. pulse begin_of_sample to reset the sample FIFO and the packetizer;
//   2. wait out the FIFO reset recovery time;
//   3. arm a mask/value/edge trigger on the live channels;
//   4. keep sample_running high for the programmed number of samples;
//   5. while running, force periodic keyframes.
//
// Handshake note: cmd_start and cmd_stop are single-cycle command strobes
// with no ready. Each is acted on in the cycle it is high if the current
// state accepts it, and is otherwise dropped. cmd_stop has priority over
// cmd_start in the same cycle.
//
// Every output is a flop. Each one is loaded from the next-state values, so
// it describes the state the block is in during the cycle it is seen.
module sample_capture_ctrl #(
  parameter int unsigned CHANNEL           = 16,
  parameter int unsigned COUNT_BITS        = 32,
  parameter int unsigned RST_CYCLES        = 4,
  parameter int unsigned SETTLE_CYCLES     = 16,
  parameter int unsigned KEYFRAME_INTERVAL = 256
) (
  input  logic                  sample_clk,
  input  logic                  sample_clk_rst_n,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic [CHANNEL-1:0]    trig_mask,
  input  logic [CHANNEL-1:0]    trig_value,
  input  logic [CHANNEL-1:0]    trig_edge,
  input  logic [COUNT_BITS-1:0] sample_limit,
  input  logic [CHANNEL-1:0]    channel_in,
  output logic                  begin_of_sample,
  output logic                  sample_running,
  output logic                  force_keyframe,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic                  aborted,
  output logic [COUNT_BITS-1:0] sample_count,
  output logic [2:0]            fsm_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RESET   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_ARMED   = 3'd3;
  localparam logic [2:0] S_RUNNING = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Last value of the phase counter in each timed state.
  // RST_CYCLES is at least 1.
  // SETTLE_LAST is only used when SETTLE_CYCLES is nonzero.
  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;

  // Cycles spent so far in RESET or SETTLE.
  logic [31:0]           phase_cnt;
  logic [31:0]           phase_nxt;

  // Running cycles since the last forced keyframe.
  logic [31:0]           kf_cnt;
  logic [31:0]           kf_nxt;
  logic [31:0]           kf_adv;

  logic [COUNT_BITS-1:0] count_nxt;
  logic [COUNT_BITS-1:0] count_sat;

  // Session configuration, captured when the start command is accepted.
  logic [CHANNEL-1:0]    mask_q;
  logic [CHANNEL-1:0]    value_q;
  logic [CHANNEL-1:0]    edge_q;
  logic [COUNT_BITS-1:0] limit_q;

  // Channel levels seen in the previous ARMED cycle.
  logic [CHANNEL-1:0]    prev_ch;
  logic                  prev_valid;

  logic                  match;
  logic                  start_ok;
  logic                  latch_en;
  logic                  clear_flags;
  logic                  trig_set;
  logic                  abort_set;

  assign fsm_state = state;
  assign start_ok  = cmd_start && !cmd_stop;

  // The sample count saturates at all-ones instead of wrapping.
  assign count_sat = (&sample_count) ? sample_count
                                     : sample_count + COUNT_BITS'(1);

  // Advance the keyframe spacing counter:
  //   interval 0 : the counter leaves zero and stays there, so only the
  //                first running cycle is a keyframe;
  //   interval 1 : the counter stays at zero, so every cycle is a keyframe;
  //   otherwise  : the counter wraps at interval-1.
  always_comb begin
    kf_adv = kf_cnt;
    if (KEYFRAME_INTERVAL == 0) begin
      kf_adv = 32'd1;
    end else if (KEYFRAME_INTERVAL == 1) begin
      kf_adv = 32'd0;
    end else if (kf_cnt == 32'(KEYFRAME_INTERVAL - 1)) begin
      kf_adv = 32'd0;
    end else begin
      kf_adv = kf_cnt + 32'd1;
    end
  end

  // Trigger condition: every masked channel must match its level.
  // Channels with the edge bit set must also have changed since the
  // previous ARMED cycle. An empty mask matches at once.
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < int'(CHANNEL); i++) begin
      if (mask_q[i]) begin
        if (channel_in[i] != value_q[i]) begin
          match = 1'b0;
        end
        if (edge_q[i] && !(prev_valid && (prev_ch[i] != channel_in[i]))) begin
          match = 1'b0;
        end
      end
    end
  end

  // Next-state logic and the per-state counter updates.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_cnt;
    kf_nxt      = kf_cnt;
    count_nxt   = sample_count;
    latch_en    = 1'b0;
    clear_flags = 1'b0;
    trig_set    = 1'b0;
    abort_set   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_nxt   = S_RESET;
          phase_nxt   = 32'd0;
          count_nxt   = '0;
          latch_en    = 1'b1;
          clear_flags = 1'b1;
        end
      end
      S_RESET: begin
        if (cmd_stop) begin
          state_nxt = S_IDLE;
        end else if (phase_cnt == RST_LAST) begin
          phase_nxt = 32'd0;
          state_nxt = (SETTLE_CYCLES == 0) ? S_ARMED : S_SETTLE;
        end else begin
          phase_nxt = phase_cnt + 32'd1;
        end
      end
      S_SETTLE: begin
        if (cmd_stop) begin
          state_nxt = S_IDLE;
        end else if (phase_cnt == SETTLE_LAST) begin
          phase_nxt = 32'd0;
          state_nxt = S_ARMED;
        end else begin
          phase_nxt = phase_cnt + 32'd1;
        end
      end
      S_ARMED: begin
        if (cmd_stop) begin
          state_nxt = S_IDLE;
        end else if (match) begin
          state_nxt = S_RUNNING;
          trig_set  = 1'b1;
          kf_nxt    = 32'd0;
        end
      end
      S_RUNNING: begin
        count_nxt = count_sat;
        kf_nxt    = kf_adv;
        if (cmd_stop) begin
          state_nxt = S_DONE;
          abort_set = 1'b1;
        end else if ((limit_q != '0) && (count_sat == limit_q)) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge sample_clk) begin
    if (!sample_clk_rst_n) begin
      state           <= S_IDLE;
      phase_cnt       <= 32'd0;
      kf_cnt          <= 32'd0;
      begin_of_sample <= 1'b0;
      sample_running  <= 1'b0;
      force_keyframe  <= 1'b0;
      busy            <= 1'b0;
      triggered       <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      sample_count    <= '0;
    end else begin
      state           <= state_nxt;
      phase_cnt       <= phase_nxt;
      kf_cnt          <= kf_nxt;
      begin_of_sample <= (state_nxt == S_RESET);
      sample_running  <= (state_nxt == S_RUNNING);
      force_keyframe  <= (state_nxt == S_RUNNING) && (kf_nxt == 32'd0);
      busy            <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done            <= (state_nxt == S_DONE);
      sample_count    <= count_nxt;
      if (clear_flags) begin
        triggered <= 1'b0;
        aborted   <= 1'b0;
      end else begin
        if (trig_set) begin
          triggered <= 1'b1;
        end
        if (abort_set) begin
          aborted <= 1'b1;
        end
      end
    end
  end

  // Latch the session configuration when a start is accepted.
  always_ff @(posedge sample_clk) begin
    if (!sample_clk_rst_n) begin
      mask_q  <= '0;
      value_q <= '0;
      edge_q  <= '0;
      limit_q <= '0;
    end else if (latch_en) begin
      mask_q  <= trig_mask;
      value_q <= trig_value;
      edge_q  <= trig_edge;
      limit_q <= sample_limit;
    end
  end

  // Edge history. It is refreshed every ARMED cycle. It reads as invalid on
  // the first ARMED cycle, because the state before that was not ARMED.
  always_ff @(posedge sample_clk) begin
    if (!sample_clk_rst_n) begin
      prev_ch    <= '0;
      prev_valid <= 1'b0;
    end else if (state == S_ARMED) begin
      prev_ch    <= channel_in;
      prev_valid <= 1'b1;
    end else begin
      prev_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Testbench for sample_capture_ctrl.
// A behavioural session model is stepped on every clock edge with the same
// inputs the DUT sees. Its predicted outputs go through an expected queue
// and are compared with the DUT one cycle at a time. Directed scenarios add
// explicit end-of-scenario checks.
module tb_sample_capture_ctrl;

  localparam int KI = 4;
  localparam int RSTC = 4;
  localparam int SETC = 16;
  localparam int W = 39;

  // Model phases
  localparam int P_IDLE = 0;
  localparam int P_RST  = 1;
  localparam int P_SET  = 2;
  localparam int P_ARM  = 3;
  localparam int P_RUN  = 4;
  localparam int P_DONE = 5;

  logic        clk;
  logic        rst_n;
  logic        cmd_start;
  logic        cmd_stop;
  logic [15:0] trig_mask;
  logic [15:0] trig_value;
  logic [15:0] trig_edge;
  logic [31:0] sample_limit;
  logic [15:0] channel_in;
  logic        begin_of_sample;
  logic        sample_running;
  logic        force_keyframe;
  logic        busy;
  logic        triggered;
  logic        done;
  logic        aborted;
  logic [31:0] sample_count;
  logic [2:0]  fsm_state;

  sample_capture_ctrl #(
    .CHANNEL(16),
    .COUNT_BITS(32),
    .RST_CYCLES(RSTC),
    .SETTLE_CYCLES(SETC),
    .KEYFRAME_INTERVAL(KI)
  ) dut (
    .sample_clk(clk),
    .sample_clk_rst_n(rst_n),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .trig_mask(trig_mask),
    .trig_value(trig_value),
    .trig_edge(trig_edge),
    .sample_limit(sample_limit),
    .channel_in(channel_in),
    .begin_of_sample(begin_of_sample),
    .sample_running(sample_running),
    .force_keyframe(force_keyframe),
    .busy(busy),
    .triggered(triggered),
    .done(done),
    .aborted(aborted),
    .sample_count(sample_count),
    .fsm_state(fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];

  // Model state
  int          m_ph;
  int          m_age;
  logic [15:0] c_mask;
  logic [15:0] c_val;
  logic [15:0] c_edge;
  logic [31:0] c_lim;
  bit          m_trig;
  bit          m_abort;
  longint      m_cnt;
  logic [15:0] m_prev;
  bit          m_prev_ok;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_outputs();
    logic kf;
    kf = (m_ph == P_RUN) && ((KI == 0) ? (m_age == 0) : ((m_age % KI) == 0));
    return {(m_ph == P_RST), (m_ph == P_RUN), kf,
            (m_ph >= P_RST && m_ph <= P_RUN), m_trig, (m_ph == P_DONE),
            m_abort, m_cnt[31:0]};
  endfunction

  // Advances the model by one clock edge, using the inputs the DUT samples.
  task automatic model_step();
    bit hit;
    if (!rst_n) begin
      m_ph = P_IDLE; m_age = 0; m_trig = 0; m_abort = 0; m_cnt = 0;
      m_prev_ok = 0;
      c_mask = '0; c_val = '0; c_edge = '0; c_lim = '0;
    end else begin
      case (m_ph)
        P_IDLE, P_DONE: begin
          if (cmd_start && !cmd_stop) begin
            c_mask = trig_mask; c_val = trig_value; c_edge = trig_edge;
            c_lim = sample_limit;
            m_trig = 0; m_abort = 0; m_cnt = 0;
            m_ph = P_RST; m_age = 0;
          end
        end
        P_RST: begin
          if (cmd_stop) m_ph = P_IDLE;
          else if (m_age + 1 == RSTC) begin
            m_age = 0;
            m_ph = (SETC == 0) ? P_ARM : P_SET;
            m_prev_ok = 0;
          end else m_age++;
        end
        P_SET: begin
          if (cmd_stop) m_ph = P_IDLE;
          else if (m_age + 1 == SETC) begin
            m_age = 0; m_ph = P_ARM; m_prev_ok = 0;
          end else m_age++;
        end
        P_ARM: begin
          hit = 1;
          for (int i = 0; i < 16; i++) begin
            if (c_mask[i]) begin
              if (channel_in[i] != c_val[i]) hit = 0;
              if (c_edge[i] && !(m_prev_ok && m_prev[i] != channel_in[i])) hit = 0;
            end
          end
          m_prev = channel_in;
          m_prev_ok = 1;
          if (cmd_stop) m_ph = P_IDLE;
          else if (hit) begin
            m_ph = P_RUN; m_age = 0; m_trig = 1;
          end
        end
        P_RUN: begin
          if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
          if (cmd_stop) begin
            m_ph = P_DONE; m_abort = 1;
          end else if (c_lim != 0 && (m_age + 1) == c_lim) begin
            m_ph = P_DONE;
          end else m_age++;
        end
        default: m_ph = P_IDLE;
      endcase
    end
    exp_q.push_back(model_outputs());
  endtask

  // One clock: step the model at the edge, compare the DUT outputs just after it.
  task automatic cyc();
    logic [W-1:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("begin_of_sample", begin_of_sample, e[38]);
    check("sample_running", sample_running, e[37]);
    check("force_keyframe", force_keyframe, e[36]);
    check("busy", busy, e[35]);
    check("triggered", triggered, e[34]);
    check("done", done, e[33]);
    check("aborted", aborted, e[32]);
    check("sample_count", sample_count, e[31:0]);
  endtask

  // Driver: single-cycle start with a given configuration
  task automatic drive_start(input logic [15:0] mk, input logic [15:0] vl,
                             input logic [15:0] ed, input logic [31:0] lim);
    trig_mask = mk; trig_value = vl; trig_edge = ed; sample_limit = lim;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
  endtask

  // Bounded wait: 0 = running, 1 = done, 2 = sample_count == 5
  task automatic wait_for(input string tag, input int which, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      ok = (which == 0) ? sample_running : (which == 1) ? done : (sample_count == 32'd5);
      if (ok) break;
      cyc();
    end
    ok = (which == 0) ? sample_running : (which == 1) ? done : (sample_count == 32'd5);
    check(tag, ok, 1'b1);
  endtask

  initial begin
    int first_run;
    int n_bos;
    int n_run;
    int n_kf;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
    trig_mask = '0; trig_value = '0; trig_edge = '0; sample_limit = '0;
    channel_in = '0;
    m_prev = '0;
    repeat (3) cyc();
    check("reset_busy", busy, 1'b0);
    check("reset_count", sample_count, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic session: empty mask, limit 10
    first_run = -1; n_bos = 0; n_run = 0; n_kf = 0;
    drive_start(16'h0, 16'h0, 16'h0, 32'd10);
    check("t1_bos_cycle1", begin_of_sample, 1'b1);
    n_bos = 1;
    for (int i = 2; i <= 40; i++) begin
      cyc();
      if (begin_of_sample) n_bos++;
      if (sample_running) n_run++;
      if (force_keyframe) n_kf++;
      if (sample_running && first_run < 0) first_run = i;
    end
    check("t1_bos_len", n_bos, 4);
    check("t1_first_run", first_run, 22);
    check("t1_run_len", n_run, 10);
    check("t1_kf_cnt", n_kf, 3);
    check("t1_done", done, 1'b1);
    check("t1_count", sample_count, 32'd10);

    // Edge trigger: ch0 held high never fires; a 0 then 1 fires
    channel_in = 16'h0001;
    drive_start(16'h0001, 16'h0001, 16'h0001, 32'd5);
    repeat (30) cyc();
    check("t2_no_trig", triggered, 1'b0);
    check("t2_not_running", sample_running, 1'b0);
    channel_in = 16'h0000;
    cyc();
    check("t2_still_idle", sample_running, 1'b0);
    channel_in = 16'h0001;
    cyc();
    check("t2_run_after_edge", sample_running, 1'b1);
    wait_for("t2_wait_done", 1, 20);
    check("t2_count", sample_count, 32'd5);

    // Unlimited run stopped after 9 running cycles
    n_kf = 0;
    drive_start(16'h0, 16'h0, 16'h0, 32'd0);
    wait_for("t3_wait_run", 0, 40);
    for (int i = 0; i < 8; i++) begin
      if (force_keyframe) n_kf++;
      cyc();
    end
    if (force_keyframe) n_kf++;
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    check("t3_kf_cnt", n_kf, 3);
    check("t3_done", done, 1'b1);
    check("t3_aborted", aborted, 1'b1);
    check("t3_count", sample_count, 32'd9);

    // Stop during SETTLE, start+stop while IDLE, then a fresh start
    drive_start(16'h0, 16'h0, 16'h0, 32'd3);
    repeat (7) cyc();
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    check("t4_stop_idle", busy, 1'b0);
    check("t4_stop_bos", begin_of_sample, 1'b0);
    check("t4_stop_done", done, 1'b0);
    cmd_start = 1'b1; cmd_stop = 1'b1;
    cyc();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    cyc();
    check("t4_both_busy", busy, 1'b0);
    check("t4_both_bos", begin_of_sample, 1'b0);
    n_bos = 0;
    drive_start(16'h0, 16'h0, 16'h0, 32'd3);
    if (begin_of_sample) n_bos++;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (begin_of_sample) n_bos++;
    end
    check("t4_bos_len", n_bos, 4);
    wait_for("t4_wait_done", 1, 40);

    // Trigger inputs changed after start are ignored; reset mid-run
    channel_in = 16'h0000;
    drive_start(16'h00F0, 16'h0050, 16'h0000, 32'd20);
    trig_mask = 16'h0000; trig_value = 16'hFFFF; sample_limit = 32'd1;
    repeat (25) cyc();
    check("t5_no_trig", triggered, 1'b0);
    channel_in = 16'h0A5A;
    cyc();
    check("t5_run", sample_running, 1'b1);
    wait_for("t5_wait_cnt5", 2, 10);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("t5_rst_out",
          {begin_of_sample, sample_running, force_keyframe, busy, triggered, done, aborted},
          7'd0);
    check("t5_rst_count", sample_count, 32'd0);

    // Random sessions
    for (int n = 0; n < 2500; n++) begin
      channel_in = 16'($urandom);
      cmd_start = ($urandom_range(0, 19) == 0);
      cmd_stop = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      trig_mask = 16'($urandom & $urandom & $urandom);
      trig_value = 16'($urandom);
      trig_edge = trig_mask & 16'($urandom);
      sample_limit = 32'($urandom_range(0, 12));
      cyc();
    end
    cmd_start = 1'b0; cmd_stop = 1'b0; rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
Sequences one capture session of the signal sampler in the sample_clk domain, ahead of the packetizer. On a start command it pulses begin_of_sample to reset the sample FIFO and packetizer write side, then waits out FIFO reset recovery. It then arms a mask/value/edge trigger on the live channel inputs. After the trigger it holds sample_running for a programmed number of samples and forces periodic keyframes so the packetizer can start and resynchronise its stream.

Parameters:
CHANNEL, 16, number of sampled channels
COUNT_BITS, 32, width of sample_limit and sample_count
RST_CYCLES, 4, cycles begin_of_sample is held high (>=1)
SETTLE_CYCLES, 16, idle cycles after reset before arming (>=0; covers FIFO rst busy)
KEYFRAME_INTERVAL, 256, running cycles between forced keyframes; 0 = first running cycle only

Ports:
sample_clk  in  1  sole clock
sample_clk_rst_n  in  1  synchronous, active-low reset
cmd_start  in  1  single-cycle start request
cmd_stop  in  1  single-cycle abort request
trig_mask  in  CHANNEL  1 = channel participates in trigger
trig_value  in  CHANNEL  required level (or post-edge level) per channel
trig_edge  in  CHANNEL  1 = channel must also have changed since previous cycle
sample_limit  in  COUNT_BITS  samples to capture; 0 = unlimited until cmd_stop
channel_in  in  CHANNEL  live (already synchronised) channel levels
begin_of_sample  out  1  FIFO/packetizer reset pulse
sample_running  out  1  capture window active
force_keyframe  out  1  request to mark the current sample as a keyframe (all diff bits set)
busy  out  1  state not IDLE and not DONE
triggered  out  1  trigger has fired in this session (sticky until next start)
done  out  1  session finished (level)
aborted  out  1  session ended by cmd_stop (level, valid with done)
sample_count  out  COUNT_BITS  running-cycle count of current session

Behaviour:
- Reset (sample_clk_rst_n=0 at a sample_clk edge): state IDLE; all outputs 0; sample_count 0.
- States: IDLE, RESET, SETTLE, ARMED, RUNNING, DONE.
- IDLE/DONE + cmd_start at cycle t:
  - enter RESET at t+1;
  - latch trig_mask/value/edge and sample_limit at t (later input changes are ignored);
  - clear triggered, done, aborted, sample_count.
- RESET: begin_of_sample=1 for exactly RST_CYCLES cycles, then SETTLE.
- SETTLE: begin_of_sample=0; stay SETTLE_CYCLES cycles (0 = go straight to ARMED); then ARMED.
- ARMED:
  - prev register captures channel_in every ARMED cycle; a prev_valid flag is cleared on entry and set after the first ARMED cycle.
  - match = AND over i with mask[i]=1 of (channel_in[i]==value[i]) && (!edge[i] || (prev_valid && prev[i]!=channel_in[i])).
  - Empty mask means match=1 on the first ARMED cycle.
  - An edge term can never match on the first ARMED cycle.
  - match at cycle k: triggered=1 and RUNNING at k+1.
- RUNNING:
  - sample_running=1.
  - sample_count increments by 1 every RUNNING cycle and saturates at all-ones.
  - With sample_limit=N>0, sample_running is high for exactly N cycles, then the state goes to DONE.
  - With sample_limit=0, RUNNING lasts until cmd_stop.
- force_keyframe:
  - Internal kf_cnt is cleared on entry to RUNNING; force_keyframe = RUNNING && kf_cnt==0.
  - kf_cnt wraps at KEYFRAME_INTERVAL-1.
  - KEYFRAME_INTERVAL=0 or 1: high on the first RUNNING cycle only (0) or every cycle (1).
- DONE: done=1; sample_running=0; sample_count holds; waits for cmd_start.
- cmd_stop:
  - In RESET/SETTLE/ARMED: go to IDLE next cycle; begin_of_sample drops immediately next cycle; done=0.
  - In RUNNING: go to DONE next cycle with aborted=1.
  - In IDLE/DONE: ignored.
- cmd_stop and cmd_start in the same cycle: stop wins; start is discarded.
- cmd_start while busy: ignored; no latch update.
- Limit completion and cmd_stop in the same cycle: DONE with aborted=1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Defaults, mask=0, limit=10, start at cycle 0 -> begin_of_sample high cycles 1-4; SETTLE 5-20; ARMED 21; sample_running 22-31; force_keyframe at 22 only; done=1 from 32; sample_count=10.
- mask=0x0001, value=0x0001, edge=0x0001, ch0 held 1 throughout ARMED -> never triggers; ch0 0 then 1 -> running starts the cycle after the rising sample.
- limit=0, KEYFRAME_INTERVAL=4, cmd_stop after 9 running cycles -> force_keyframe on running cycles 0, 4, 8; done=1, aborted=1; sample_count=9.
- cmd_start and cmd_stop asserted together while IDLE -> stays IDLE; no begin_of_sample pulse.
- cmd_stop during SETTLE -> IDLE next cycle; a new cmd_start then produces a full 4-cycle begin_of_sample pulse.
- Reset asserted mid-RUNNING (count=5) -> next cycle all outputs 0, IDLE; trig_* changed during ARMED have no effect on the latched condition.
